// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Instruction fetch stage ahead of decode. It generates sequential word-aligned
// fetch addresses and issues them to instruction memory over a req/gnt/rvalid
// handshake. Returned words are buffered together with their PCs in a small
// FIFO, and decode pops that FIFO through a valid/ready handshake. A redirect
// flushes the FIFO, marks in-flight responses as stale, and restarts fetch at
// the target address.
//
// Parameters
//   RESET_PC  first fetch address after reset (word aligned)
//   DEPTH     FIFO entries and in-flight request limit (power of 2, >= 2)
//
// Ports
//   clk, reset_n                      clock, asynchronous active-low reset
//   imem_req, imem_addr               fetch request and its byte address
//   imem_gnt                          memory accepts the request this cycle
//   imem_rvalid, imem_rdata           in-order response, one per grant
//   redirect_valid, redirect_pc       one-cycle restart pulse and its target
//   instr_valid, instr_data, instr_pc FIFO head presented to decode
//   instr_ready                       decode pops the head when valid
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr_data,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
);

    localparam int            PW      = $clog2(DEPTH);
    localparam int            CW      = $clog2(DEPTH + 1);
    localparam logic [CW:0]   DEPTH_C = DEPTH[CW:0];
    localparam logic [CW-1:0] FULL    = DEPTH[CW-1:0];

    logic          run;
    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [CW-1:0] occ;
    logic [CW-1:0] outst;
    logic [CW-1:0] drop;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [31:0]   data_mem [DEPTH];
    logic [31:0]   pc_mem   [DEPTH];

    logic          grant;
    logic          push;
    logic          pop;
    logic          discard;
    logic [CW:0]   credit_used;
    logic [CW-1:0] outst_nxt;
    logic [CW-1:0] grant_ext;
    logic [CW-1:0] resp_ext;
    logic [CW-1:0] push_ext;
    logic [CW-1:0] pop_ext;
    logic [31:0]   redirect_aligned;

    // Credit is taken from registered counts only, so imem_req never depends
    // combinationally on instr_ready or imem_rvalid. The sum of occ and outst
    // only rises on a grant, so a raised request holds until it is granted.
    assign credit_used = {1'b0, occ} + {1'b0, outst};
    assign imem_req    = run && (credit_used < DEPTH_C);
    assign imem_addr   = fetch_pc;

    assign grant   = imem_req && imem_gnt;
    assign pop     = instr_valid && instr_ready;
    assign discard = imem_rvalid && (drop != '0);
    // A response landing in a redirect cycle belongs to the old path.
    assign push    = imem_rvalid && (drop == '0) && !redirect_valid;

    assign grant_ext = {{(CW-1){1'b0}}, grant};
    assign resp_ext  = {{(CW-1){1'b0}}, imem_rvalid};
    assign push_ext  = {{(CW-1){1'b0}}, push};
    assign pop_ext   = {{(CW-1){1'b0}}, pop};

    // Outstanding count after this cycle's grant and response; on a redirect
    // every one of these is stale, including a grant made in that same cycle.
    assign outst_nxt = outst + grant_ext - resp_ext;

    assign redirect_aligned = redirect_pc & 32'hFFFF_FFFC;

    assign instr_valid = (occ != '0);
    assign instr_data  = instr_valid ? data_mem[rd_ptr] : 32'h0;
    assign instr_pc    = instr_valid ? pc_mem[rd_ptr]   : 32'h0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run      <= 1'b0;
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            occ      <= '0;
            outst    <= '0;
            drop     <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            run   <= 1'b1;
            outst <= outst_nxt;
            if (redirect_valid) begin
                fetch_pc <= redirect_aligned;
                resp_pc  <= redirect_aligned;
                occ      <= '0;
                drop     <= outst_nxt;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
            end else begin
                if (grant) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (push) begin
                    resp_pc <= resp_pc + 32'd4;
                    wr_ptr  <= wr_ptr + 1'b1;
                end
                if (discard) begin
                    drop <= drop - 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                occ <= occ + push_ext - pop_ext;
            end
        end
    end

    // Payload storage; contents are only visible through occ, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr] <= imem_rdata;
            pc_mem[wr_ptr]   <= resp_pc;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (reset_n) begin
            assert (!(imem_rvalid && (occ == FULL) && !pop));
            assert (!(imem_rvalid && (outst == '0)));
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
`timescale 1ns/1ps
module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        instr_valid;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b0;

    int          compared = 0;
    int          mismatched = 0;
    int          cyc = 0;
    int          lat = 1;
    logic [31:0] exp_pc = 32'h0;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;
    req_t mq[$];

    instr_fetch_unit #(
        .RESET_PC(RESET_PC),
        .DEPTH   (DEPTH)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .instr_valid   (instr_valid),
        .instr_data    (instr_data),
        .instr_pc      (instr_pc),
        .instr_ready   (instr_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return 32'h1000_0000 + {2'b00, a[31:2]};
    endfunction

    // Memory model: grants are recorded mid-cycle, answered in order 'lat' cycles later.
    always @(negedge clk) begin
        if (!reset_n) mq.delete();
        else if (imem_req && imem_gnt) mq.push_back('{imem_addr, cyc + lat});
    end

    always begin
        @(posedge clk);
        cyc = cyc + 1;
        #1;
        if (!reset_n) begin
            mq.delete();
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
        end else if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = word_of(mq[0].addr);
            void'(mq.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; imem_gnt = 1'b1; instr_ready = 1'b1; redirect_valid = 1'b0; lat = 1;
        repeat (3) tick();
        @(negedge clk);
        compared++; if (imem_req !== 1'b0) begin mismatched++; $display("FAIL reset_req: got %b expected 0", imem_req); end
        compared++; if (instr_valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid: got %b expected 0", instr_valid); end
        compared++; if (instr_data !== 32'h0) begin mismatched++; $display("FAIL reset_data: got %h expected 0", instr_data); end
        compared++; if (instr_pc !== 32'h0) begin mismatched++; $display("FAIL reset_pc: got %h expected 0", instr_pc); end
        compared++; if (imem_addr !== RESET_PC) begin mismatched++; $display("FAIL reset_addr: got %h expected %h", imem_addr, RESET_PC); end
    endtask

    task automatic test_stream();
        tick(); reset_n = 1'b1;
        tick(); @(negedge clk);
        compared++;
        if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
            mismatched++; $display("FAIL first_req: got req=%b addr=%h expected req=1 addr=%h", imem_req, imem_addr, RESET_PC);
        end
        tick(); @(negedge clk);
        compared++; if (instr_valid !== 1'b0) begin mismatched++; $display("FAIL stream_latency: got valid=%b expected 0", instr_valid); end
        exp_pc = RESET_PC;
        for (int i = 0; i < 64; i++) begin
            tick(); @(negedge clk);
            compared++;
            if (instr_valid !== 1'b1 || instr_pc !== exp_pc || instr_data !== word_of(exp_pc)) begin
                mismatched++;
                $display("FAIL stream[%0d]: got v=%b pc=%h data=%h expected v=1 pc=%h data=%h", i, instr_valid, instr_pc, instr_data, exp_pc, word_of(exp_pc));
            end
            exp_pc += 32'd4;
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 10; i++) begin
            tick(); instr_ready = 1'b0; @(negedge clk);
            compared++;
            if (instr_valid !== 1'b1 || instr_pc !== exp_pc || instr_data !== word_of(exp_pc)) begin
                mismatched++;
                $display("FAIL bp_hold[%0d]: got v=%b pc=%h expected v=1 pc=%h", i, instr_valid, instr_pc, exp_pc);
            end
        end
        compared++;
        if (imem_req !== 1'b0 || imem_addr !== exp_pc + 32'd16) begin
            mismatched++; $display("FAIL bp_credit: got req=%b addr=%h expected req=0 addr=%h", imem_req, imem_addr, exp_pc + 32'd16);
        end
        for (int i = 0; i < 20; i++) begin
            tick(); instr_ready = 1'b1; @(negedge clk);
            compared++;
            if (instr_valid !== 1'b1 || instr_pc !== exp_pc || instr_data !== word_of(exp_pc)) begin
                mismatched++;
                $display("FAIL bp_drain[%0d]: got v=%b pc=%h data=%h expected v=1 pc=%h data=%h", i, instr_valid, instr_pc, instr_data, exp_pc, word_of(exp_pc));
            end
            exp_pc += 32'd4;
        end
    endtask

    task automatic test_redirect_inflight();
        for (int i = 0; i < 8; i++) begin
            tick(); imem_gnt = 1'b0; @(negedge clk);
            if (instr_valid && instr_ready) begin
                compared++;
                if (instr_pc !== exp_pc || instr_data !== word_of(exp_pc)) begin
                    mismatched++; $display("FAIL rd_drain[%0d]: got pc=%h expected pc=%h", i, instr_pc, exp_pc);
                end
                exp_pc += 32'd4;
            end
        end
        compared++;
        if (imem_req !== 1'b1 || imem_addr !== exp_pc) begin
            mismatched++; $display("FAIL rd_idle_req: got req=%b addr=%h expected req=1 addr=%h", imem_req, imem_addr, exp_pc);
        end
        lat = 3;
        for (int i = 0; i <= 10; i++) begin
            tick();
            imem_gnt       = (i != 2);
            redirect_valid = (i == 2);
            redirect_pc    = 32'h0000_0103;
            @(negedge clk);
            if (i == 2) exp_pc = 32'h0000_0100;
            if (i == 3) begin
                compared++;
                if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0100) begin
                    mismatched++; $display("FAIL rd_new_addr: got req=%b addr=%h expected req=1 addr=00000100", imem_req, imem_addr);
                end
            end
            if (i <= 6) begin
                compared++;
                if (instr_valid !== 1'b0) begin
                    mismatched++; $display("FAIL rd_squash[%0d]: got v=%b pc=%h expected v=0", i, instr_valid, instr_pc);
                end
            end else begin
                compared++;
                if (instr_valid !== 1'b1 || instr_pc !== exp_pc || instr_data !== word_of(exp_pc)) begin
                    mismatched++; $display("FAIL rd_newpath[%0d]: got v=%b pc=%h expected v=1 pc=%h", i, instr_valid, instr_pc, exp_pc);
                end
                exp_pc += 32'd4;
            end
        end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 10; i++) begin
            tick(); imem_gnt = 1'b0; @(negedge clk);
            if (instr_valid && instr_ready) begin
                compared++;
                if (instr_pc !== exp_pc || instr_data !== word_of(exp_pc)) begin
                    mismatched++; $display("FAIL sim_drain[%0d]: got pc=%h expected pc=%h", i, instr_pc, exp_pc);
                end
                exp_pc += 32'd4;
            end
        end
        lat = 1;
        for (int k = 0; k <= 10; k++) begin
            tick();
            imem_gnt       = 1'b1;
            redirect_valid = (k == 5);
            redirect_pc    = 32'h0000_0200;
            @(negedge clk);
            if (k == 5) begin
                compared++;
                if (!(imem_rvalid && imem_req && imem_gnt && instr_valid && instr_ready)) begin
                    mismatched++; $display("FAIL sim_setup: got rvalid=%b req=%b valid=%b expected all 1", imem_rvalid, imem_req, instr_valid);
                end
            end
            if (k == 6) begin
                compared++;
                if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0200) begin
                    mismatched++; $display("FAIL sim_new_addr: got req=%b addr=%h expected req=1 addr=00000200", imem_req, imem_addr);
                end
            end
            if (k <= 1 || k == 6 || k == 7) begin
                compared++;
                if (instr_valid !== 1'b0) begin
                    mismatched++; $display("FAIL sim_empty[%0d]: got v=%b pc=%h expected v=0", k, instr_valid, instr_pc);
                end
            end else begin
                compared++;
                if (instr_valid !== 1'b1 || instr_pc !== exp_pc || instr_data !== word_of(exp_pc)) begin
                    mismatched++; $display("FAIL sim_pop[%0d]: got v=%b pc=%h expected v=1 pc=%h", k, instr_valid, instr_pc, exp_pc);
                end
                exp_pc = (k == 5) ? 32'h0000_0200 : exp_pc + 32'd4;
            end
        end
    endtask

    task automatic test_stall();
        for (int t = 0; t <= 9; t++) begin
            tick();
            imem_gnt       = (t >= 6);
            redirect_valid = (t == 0 || t == 4);
            redirect_pc    = (t == 4) ? 32'h0000_0502 : 32'h0000_0400;
            @(negedge clk);
            if (t >= 1 && t <= 6) begin
                compared++;
                if (imem_req !== 1'b1 || imem_addr !== ((t <= 4) ? 32'h0000_0400 : 32'h0000_0500)) begin
                    mismatched++; $display("FAIL stall_addr[%0d]: got req=%b addr=%h expected req=1 addr=%h", t, imem_req, imem_addr, (t <= 4) ? 32'h0000_0400 : 32'h0000_0500);
                end
            end
            if (t >= 1 && t <= 7) begin
                compared++;
                if (instr_valid !== 1'b0) begin
                    mismatched++; $display("FAIL stall_empty[%0d]: got v=%b pc=%h expected v=0", t, instr_valid, instr_pc);
                end
            end else begin
                compared++;
                if (instr_valid !== 1'b1 || instr_pc !== exp_pc || instr_data !== word_of(exp_pc)) begin
                    mismatched++; $display("FAIL stall_pop[%0d]: got v=%b pc=%h expected v=1 pc=%h", t, instr_valid, instr_pc, exp_pc);
                end
                exp_pc = (t == 0) ? 32'h0000_0500 : exp_pc + 32'd4;
            end
        end
    endtask

    task automatic test_wrap_reset();
        for (int w = 0; w <= 8; w++) begin
            tick();
            imem_gnt       = 1'b1;
            redirect_valid = (w == 0);
            redirect_pc    = 32'hFFFF_FFF8;
            @(negedge clk);
            if (w == 1 || w == 2) begin
                compared++;
                if (instr_valid !== 1'b0) begin
                    mismatched++; $display("FAIL wrap_empty[%0d]: got v=%b pc=%h expected v=0", w, instr_valid, instr_pc);
                end
            end else begin
                compared++;
                if (instr_valid !== 1'b1 || instr_pc !== exp_pc || instr_data !== word_of(exp_pc)) begin
                    mismatched++; $display("FAIL wrap_pop[%0d]: got v=%b pc=%h data=%h expected v=1 pc=%h data=%h", w, instr_valid, instr_pc, instr_data, exp_pc, word_of(exp_pc));
                end
                exp_pc = (w == 0) ? 32'hFFFF_FFF8 : exp_pc + 32'd4;
            end
        end
        compared++;
        if (imem_req !== 1'b1) begin mismatched++; $display("FAIL pre_reset_req: got %b expected 1", imem_req); end
        #2;
        reset_n = 1'b0;
        #1;
        compared++; if (instr_valid !== 1'b0) begin mismatched++; $display("FAIL async_valid: got %b expected 0", instr_valid); end
        compared++; if (imem_req !== 1'b0) begin mismatched++; $display("FAIL async_req: got %b expected 0", imem_req); end
        compared++; if (imem_addr !== RESET_PC) begin mismatched++; $display("FAIL async_addr: got %h expected %h", imem_addr, RESET_PC); end
        repeat (2) tick();
        reset_n = 1'b1;
        tick(); @(negedge clk);
        compared++;
        if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
            mismatched++; $display("FAIL restart_req: got req=%b addr=%h expected req=1 addr=%h", imem_req, imem_addr, RESET_PC);
        end
        tick(); @(negedge clk);
        compared++; if (instr_valid !== 1'b0) begin mismatched++; $display("FAIL restart_latency: got v=%b expected 0", instr_valid); end
        exp_pc = RESET_PC;
        for (int i = 0; i < 4; i++) begin
            tick(); @(negedge clk);
            compared++;
            if (instr_valid !== 1'b1 || instr_pc !== exp_pc || instr_data !== word_of(exp_pc)) begin
                mismatched++; $display("FAIL restart[%0d]: got v=%b pc=%h expected v=1 pc=%h", i, instr_valid, instr_pc, exp_pc);
            end
            exp_pc += 32'd4;
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_inflight();
        test_simultaneous();
        test_stall();
        test_wrap_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
